gpio_pad_ctrl: RTL

//  Per-pin GPIO controller sitting directly upstream of the P65 bidirectional pad cells.
//  - Drives each pad's I/OE/IE/PU/PD/DS0/DS1 from software-visible registers.
//  - Consumes each pad's C output through a 2-flop synchronizer.
//  - Detects rising/falling edges into sticky, maskable interrupt status.
//  - Slave on a simple single-cycle register bus.

---
 rtl/gpio_pkg.sv | 25 ++
 rtl/gpio_sync_edge.sv | 79 +++++++
 rtl/gpio_pad_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared register map and types for the GPIO pad controller.
package gpio_pkg;

    typedef logic [31:0] gpio_reg_t;

    localparam logic [5:0] GPIO_OUT_OFFS     = 6'h00;
    localparam logic [5:0] GPIO_OE_OFFS      = 6'h04;
    localparam logic [5:0] GPIO_IN_OFFS      = 6'h08;
    localparam logic [5:0] GPIO_IE_OFFS      = 6'h0C;
    localparam logic [5:0] GPIO_PU_OFFS      = 6'h10;
    localparam logic [5:0] GPIO_PD_OFFS      = 6'h14;
    localparam logic [5:0] GPIO_DS0_OFFS     = 6'h18;
    localparam logic [5:0] GPIO_DS1_OFFS     = 6'h1C;
    localparam logic [5:0] GPIO_RISE_EN_OFFS = 6'h20;
    localparam logic [5:0] GPIO_FALL_EN_OFFS = 6'h24;
    localparam logic [5:0] GPIO_STATUS_OFFS  = 6'h28;

    localparam logic [5:0] GPIO_ADDR_MASK    = 6'h3C;

    // The map is contiguous from 0x00 to STATUS, so one compare covers decode.
    function automatic logic gpio_addr_mapped(input logic [5:0] addr);
        return (addr & GPIO_ADDR_MASK) <= GPIO_STATUS_OFFS;
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Per-pin input path: 2-flop synchronizer, optional debounce (GPIO_DEBOUNCE_EN),
// previous-value flop and rise/fall event outputs.
module gpio_sync_edge
    import gpio_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pad_c_i,
    output logic in_o,
    output logic rise_o,
    output logic fall_o
);

    if (DB_CYCLES < 2) begin : g_db_cycles_below_minimum
    end

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic in_q;

    always_comb begin
        sync1_d = pad_c_i;
        sync2_d = sync1_q;
        prev_d  = in_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_d;

    // The counter tracks consecutive cycles of disagreement; any bounce back restarts it.
    always_comb begin
        cnt_d = '0;
        in_d  = in_q;
        if (sync2_q != in_q) begin
            if (cnt_q == CNT_MAX) begin
                in_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            in_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            in_q  <= in_d;
        end
    end
`else
    always_comb in_q = sync2_q;
`endif

    assign in_o   = in_q;
    assign rise_o = in_q & ~prev_q;
    assign fall_o = ~in_q & prev_q;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: register file, bus decode, edge-interrupt status and irq.
// Optional input debounce is enabled with the GPIO_DEBOUNCE_EN macro.
module gpio_pad_ctrl
    import gpio_pkg::*;
#(
    parameter int unsigned NUM_PINS  = 32,
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [5:0]          addr_i,
    input  logic [31:0]         wdata_i,
    output logic                rvalid_o,
    output logic [31:0]         rdata_o,
    output logic                err_o,
    input  logic [NUM_PINS-1:0] pad_c_i,
    output logic [NUM_PINS-1:0] pad_i_o,
    output logic [NUM_PINS-1:0] pad_oe_o,
    output logic [NUM_PINS-1:0] pad_ie_o,
    output logic [NUM_PINS-1:0] pad_pu_o,
    output logic [NUM_PINS-1:0] pad_pd_o,
    output logic [NUM_PINS-1:0] pad_ds0_o,
    output logic [NUM_PINS-1:0] pad_ds1_o,
    output logic                irq_o
);

    logic [NUM_PINS-1:0] in_vec, rise_vec, fall_vec;

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        gpio_sync_edge #(
            .DB_CYCLES (DB_CYCLES)
        ) u_sync_edge (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .pad_c_i (pad_c_i[i]),
            .in_o    (in_vec[i]),
            .rise_o  (rise_vec[i]),
            .fall_o  (fall_vec[i])
        );
    end

    logic [NUM_PINS-1:0] out_q, out_d;
    logic [NUM_PINS-1:0] oe_q, oe_d;
    logic [NUM_PINS-1:0] ie_q, ie_d;
    logic [NUM_PINS-1:0] pu_q, pu_d;
    logic [NUM_PINS-1:0] pd_q, pd_d;
    logic [NUM_PINS-1:0] ds0_q, ds0_d;
    logic [NUM_PINS-1:0] ds1_q, ds1_d;
    logic [NUM_PINS-1:0] rise_en_q, rise_en_d;
    logic [NUM_PINS-1:0] fall_en_q, fall_en_d;
    logic [NUM_PINS-1:0] status_q, status_d;
    logic                rvalid_q, rvalid_d;
    gpio_reg_t           rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                irq_q, irq_d;

    logic [5:0]          addr_w;
    logic                hit;
    logic                wr_en;
    logic                rd_en;
    logic [NUM_PINS-1:0] wdat;
    logic [NUM_PINS-1:0] clr;
    logic [NUM_PINS-1:0] set_evt;
    gpio_reg_t           rd_val;

    always_comb begin
        addr_w  = addr_i & GPIO_ADDR_MASK;
        hit     = gpio_addr_mapped(addr_i);
        wr_en   = req_i & we_i & hit;
        rd_en   = req_i & ~we_i & hit;
        wdat    = wdata_i[NUM_PINS-1:0];
        set_evt = (rise_vec & rise_en_q) | (fall_vec & fall_en_q);

        out_d     = out_q;
        oe_d      = oe_q;
        ie_d      = ie_q;
        pu_d      = pu_q;
        pd_d      = pd_q;
        ds0_d     = ds0_q;
        ds1_d     = ds1_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr       = '0;

        if (wr_en) begin
            case (addr_w)
                GPIO_OUT_OFFS:     out_d     = wdat;
                GPIO_OE_OFFS:      oe_d      = wdat;
                GPIO_IE_OFFS:      ie_d      = wdat;
                GPIO_PU_OFFS:      pu_d      = wdat;
                GPIO_PD_OFFS:      pd_d      = wdat;
                GPIO_DS0_OFFS:     ds0_d     = wdat;
                GPIO_DS1_OFFS:     ds1_d     = wdat;
                GPIO_RISE_EN_OFFS: rise_en_d = wdat;
                GPIO_FALL_EN_OFFS: fall_en_d = wdat;
                GPIO_STATUS_OFFS:  clr       = wdat;
                default:           ;
            endcase
        end

        // Set is applied after clear so a coincident event keeps the bit.
        status_d = (status_q & ~clr) | set_evt;
    end

    always_comb begin
        rd_val = '0;
        case (addr_w)
            GPIO_OUT_OFFS:     rd_val[NUM_PINS-1:0] = out_q;
            GPIO_OE_OFFS:      rd_val[NUM_PINS-1:0] = oe_q;
            GPIO_IN_OFFS:      rd_val[NUM_PINS-1:0] = in_vec;
            GPIO_IE_OFFS:      rd_val[NUM_PINS-1:0] = ie_q;
            GPIO_PU_OFFS:      rd_val[NUM_PINS-1:0] = pu_q;
            GPIO_PD_OFFS:      rd_val[NUM_PINS-1:0] = pd_q;
            GPIO_DS0_OFFS:     rd_val[NUM_PINS-1:0] = ds0_q;
            GPIO_DS1_OFFS:     rd_val[NUM_PINS-1:0] = ds1_q;
            GPIO_RISE_EN_OFFS: rd_val[NUM_PINS-1:0] = rise_en_q;
            GPIO_FALL_EN_OFFS: rd_val[NUM_PINS-1:0] = fall_en_q;
            GPIO_STATUS_OFFS:  rd_val[NUM_PINS-1:0] = status_q;
            default:           rd_val = '0;
        endcase

        rvalid_d = req_i;
        rdata_d  = rd_en ? rd_val : '0;
        err_d    = req_i & ~hit;
        irq_d    = |(status_q & (rise_en_q | fall_en_q));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q     <= '0;
            oe_q      <= '0;
            ie_q      <= '1;
            pu_q      <= '0;
            pd_q      <= '0;
            ds0_q     <= '0;
            ds1_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            oe_q      <= oe_d;
            ie_q      <= ie_d;
            pu_q      <= pu_d;
            pd_q      <= pd_d;
            ds0_q     <= ds0_d;
            ds1_q     <= ds1_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            irq_q     <= irq_d;
        end
    end

    assign pad_i_o   = out_q;
    assign pad_oe_o  = oe_q;
    assign pad_ie_o  = ie_q;
    assign pad_pu_o  = pu_q;
    assign pad_pd_o  = pd_q & ~pu_q;
    assign pad_ds0_o = ds0_q;
    assign pad_ds1_o = ds1_q;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;
    assign irq_o     = irq_q;

endmodule
